// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;
   localparam int REG_W  = 5;   // register-index width
   localparam int LOAD_W = 3;   // load-type width
   localparam int WAIT_W = 8;   // memory-wait counter width

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives stage info, receives controls).
// slave:  hazard controller.
interface pipe_hazard_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [REG_W-1:0]  id_rs1;
   logic [REG_W-1:0]  id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_writeReg;
   logic [LOAD_W-1:0] ex_readMem;
   logic              ex_redirect;
   logic              mem_busy;

   logic              pc_stall;
   logic              if_id_stall;
   logic              id_ex_stall;
   logic              ex_mem_stall;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              redirect_go;
   logic              mem_timeout;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_writeReg,
             ex_readMem, ex_redirect, mem_busy,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, redirect_go, mem_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_writeReg,
             ex_readMem, ex_redirect, mem_busy,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, redirect_go, mem_timeout
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: a load in EX writes a register the ID instruction reads.
// x0 never counts as a dependency.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_writeReg,
   input  logic [LOAD_W-1:0] ex_readMem,
   output logic              load_use
);
   assign load_use = (ex_readMem != '0) & ex_writeReg & (ex_rd != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, memory-wait
// hold with deferred redirect and a sticky wait timeout.
// Optional macro PIPE_HAZARD_PERF_EN adds stall/flush/wait perf counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 64
) (
   input  logic                clk,
   input  logic                rst,
   pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]         perf_stall_cnt,
   output logic [31:0]         perf_flush_cnt,
   output logic [31:0]         perf_wait_cnt
`endif
);
   state_t            state;
   logic              pending;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_inc;
   logic              timeout;
   logic              load_use;
   logic              lu_stall;
   logic              redirect_go;
   logic              busy;

   hazard_detect u_hd (
      .id_rs1      (hz.id_rs1),
      .id_rs2      (hz.id_rs2),
      .id_use_rs1  (hz.id_use_rs1),
      .id_use_rs2  (hz.id_use_rs2),
      .ex_rd       (hz.ex_rd),
      .ex_writeReg (hz.ex_writeReg),
      .ex_readMem  (hz.ex_readMem),
      .load_use    (load_use)
   );

   // Everything is gated by rst so the pipeline sees no control while in reset.
   assign busy     = rst & hz.mem_busy;
   assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);

   // Output decode: busy dominates, then redirect (live in RUN, deferred on
   // MEM_WAIT exit), then load-use. Load-use only stalls from RUN.
   always_comb begin
      lu_stall    = 1'b0;
      redirect_go = 1'b0;
      if (rst && !hz.mem_busy) begin
         if (state == RUN) begin
            redirect_go = hz.ex_redirect;
            lu_stall    = load_use & ~hz.ex_redirect;
         end else begin
            redirect_go = pending;
         end
      end
   end

   assign hz.pc_stall     = busy | lu_stall;
   assign hz.if_id_stall  = busy | lu_stall;
   assign hz.id_ex_stall  = busy;
   assign hz.ex_mem_stall = busy;
   assign hz.if_id_flush  = redirect_go;
   assign hz.id_ex_flush  = redirect_go | lu_stall;
   assign hz.redirect_go  = redirect_go;
   assign hz.mem_timeout  = timeout;

   // FSM, deferred-redirect flag, saturating wait counter, sticky timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         pending  <= 1'b0;
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else if (hz.mem_busy) begin
         state <= MEM_WAIT;
         if (hz.ex_redirect) pending <= 1'b1;
         if (state == MEM_WAIT) begin
            wait_cnt <= wait_inc;
            if (int'(wait_inc) >= MAX_WAIT) timeout <= 1'b1;
         end
      end else begin
         state    <= RUN;
         pending  <= 1'b0;
         wait_cnt <= '0;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
         perf_wait_cnt  <= '0;
      end else begin
         if (lu_stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_go) perf_flush_cnt <= perf_flush_cnt + 32'd1;
         if (busy)        perf_wait_cnt  <= perf_wait_cnt + 32'd1;
      end
   end
`else
`endif
endmodule
